frame_scheduler: RTL and testbench

- Sequences the six filtered ADC channel words into the byte-wide serial transmit path.
- On each word_clk rising edge it snapshots all channels and emits one framed packet over a valid/ready byte handshake: sync byte, sequence number, channel bytes, check byte.
- Sits between the sinc3 filter bank and the UART/Manchester transmit chain, clocked by mclkin.
- Owns frame pacing and drops frames with a sticky flag when the link cannot keep up.

---
 rtl/frame_scheduler_if.sv | 10 +
 rtl/frame_scheduler.sv | 150 +++++++++++++++
 tb/tb_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_scheduler_if.sv
// Byte-wide valid/ready transmit link from the frame scheduler to the serial transmit chain.
// master drives tx_valid/tx_data, slave drives tx_ready.
interface frame_scheduler_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/frame_scheduler.sv
// Frame scheduler: snapshots NUM_CH channel words on a word_clk rising edge and sends SYNC, SEQ, data bytes and check byte.
// Latency: tx_valid 2 clk after the edge, then one bubble cycle between bytes; stalls hold tx_data/tx_valid until tx_ready.
// Backpressure: an edge arriving mid-frame is dropped and sets sticky overrun; FRAME_SCHED_CRC8_EN selects a CRC-8 check byte instead of XOR.
module frame_scheduler #(
    parameter int         WIDTH     = 16,
    parameter int         NUM_CH    = 6,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      word_clk,
    input  logic [NUM_CH*WIDTH-1:0]   ch_data,
    frame_scheduler_if.master         tx,
    input  logic                      ovr_clr,
    output logic                      frame_busy,
    output logic                      overrun,
    output logic [7:0]                seq_num
);
    localparam int NBYTES = 2 * NUM_CH;
    localparam int IDX_W  = $clog2(NBYTES);

    typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM} state_t;

    state_t                    state_q, state_d;
    logic [NUM_CH*WIDTH-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]          bi_q, bi_d;
    logic [7:0]                csum_q, csum_d;
    logic [7:0]                seq_q, seq_d;
    logic                      tx_valid_q, tx_valid_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      overrun_q, overrun_d;
    logic                      word_clk_q, word_clk_d;

    logic                      start;
    logic                      xfer;
    logic [WIDTH-1:0]          cur_word;
    logic [7:0]                byte_sel;

`ifdef FRAME_SCHED_CRC8_EN
    // CRC-8, poly 0x07, MSB first, one whole byte per call
    function automatic logic [7:0] csum_upd(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction
`else
    function automatic logic [7:0] csum_upd(input logic [7:0] c, input logic [7:0] b);
        return c ^ b;
    endfunction
`endif

    always_comb begin
        cur_word = snap_q[int'(bi_q[IDX_W-1:1]) * WIDTH +: WIDTH];
        case (state_q)
            SYNC:    byte_sel = SYNC_BYTE;
            SEQ:     byte_sel = seq_q;
            DATA:    byte_sel = bi_q[0] ? cur_word[7:0] : cur_word[WIDTH-1:8];
            CSUM:    byte_sel = csum_q;
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        bi_d       = bi_q;
        csum_d     = csum_q;
        seq_d      = seq_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        overrun_d  = overrun_q;
        word_clk_d = word_clk;
        start      = word_clk & ~word_clk_q;
        xfer       = tx_valid_q & tx.tx_ready;

        // set beats clear when both happen in the same cycle
        if (ovr_clr)
            overrun_d = 1'b0;
        if (start && state_q != IDLE)
            overrun_d = 1'b1;

        if (state_q == IDLE) begin
            if (start) begin
                snap_d  = ch_data;
                bi_d    = '0;
                csum_d  = 8'h00;
                state_d = SYNC;
            end
        end else if (!tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = byte_sel;
        end else if (xfer) begin
            tx_valid_d = 1'b0;
            case (state_q)
                SYNC: state_d = SEQ;
                SEQ: begin
                    csum_d  = csum_upd(csum_q, tx_data_q);
                    state_d = DATA;
                end
                DATA: begin
                    csum_d = csum_upd(csum_q, tx_data_q);
                    if (bi_q == IDX_W'(NBYTES - 1)) begin
                        bi_d    = '0;
                        state_d = CSUM;
                    end else begin
                        bi_d = bi_q + 1'b1;
                    end
                end
                CSUM: begin
                    seq_d   = seq_q + 8'h01;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            bi_q       <= '0;
            csum_q     <= 8'h00;
            seq_q      <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
            word_clk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            bi_q       <= bi_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
            word_clk_q <= word_clk_d;
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign frame_busy  = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign seq_num     = seq_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: stimulus pushes expected frame bytes, a negedge monitor pops on each transfer.
// Define FRAME_SCHED_CRC8_EN to check the CRC-8 build against a bit-serial reference.
module tb_frame_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        word_clk = 1'b0;
    logic [95:0] ch_data = '0;
    logic        ovr_clr = 1'b0;
    logic        frame_busy;
    logic        overrun;
    logic [7:0]  seq_num;

    frame_scheduler_if txif();

    frame_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .word_clk   (word_clk),
        .ch_data    (ch_data),
        .tx         (txif),
        .ovr_clr    (ovr_clr),
        .frame_busy (frame_busy),
        .overrun    (overrun),
        .seq_num    (seq_num)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    bit         rdy_rand = 1'b0;
    logic       rdy_val = 1'b1;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // ch0 = w0, ch1..ch5 = wr; hand is the hand-computed XOR check byte
    task automatic push_frame(input logic [7:0] s, input logic [15:0] w0,
                              input logic [15:0] wr, input logic [7:0] hand);
        logic [7:0] chk;
        logic [7:0] b[$];
        b.push_back(s);
        b.push_back(w0[15:8]);
        b.push_back(w0[7:0]);
        for (int i = 1; i < 6; i++) begin
            b.push_back(wr[15:8]);
            b.push_back(wr[7:0]);
        end
`ifdef FRAME_SCHED_CRC8_EN
        chk = 8'h00;
        foreach (b[i]) chk = crc_ref(chk, b[i]);
`else
        chk = hand;
`endif
        exp_q.push_back(8'hA5);
        foreach (b[i]) exp_q.push_back(b[i]);
        exp_q.push_back(chk);
        ch_data = {{5{wr}}, w0};
    endtask

    task automatic start_frame();
        @(posedge clk); #1 word_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 word_clk = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && !frame_busy) done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: frame not finished, %0d bytes outstanding, busy=%b", name, exp_q.size(), frame_busy);
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, {7'd0, txif.tx_valid}, 8'h00);
        check({tag, "_tx_data"}, txif.tx_data, 8'h00);
        check({tag, "_frame_busy"}, {7'd0, frame_busy}, 8'h00);
        check({tag, "_overrun"}, {7'd0, overrun}, 8'h00);
        check({tag, "_seq_num"}, seq_num, 8'h00);
    endtask

    // ready driver: held value or random with about 40% low
    initial begin
        txif.tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            txif.tx_ready = rdy_rand ? ($urandom_range(0, 9) >= 4) : rdy_val;
        end
    end

    // monitor: transfer compare and stall stability
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests++;
                if (!(txif.tx_valid && txif.tx_data == data_prev)) begin
                    fails++;
                    $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                             txif.tx_valid, txif.tx_data, data_prev);
                end
            end
            if (txif.tx_valid && txif.tx_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %h expected no transfer", txif.tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (txif.tx_data !== e) begin
                        fails++;
                        $display("FAIL frame_byte: got %h expected %h", txif.tx_data, e);
                    end
                end
            end
            stall_prev = txif.tx_valid & ~txif.tx_ready;
            data_prev  = txif.tx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;

        // frame 1: ch0=1234, ready held, latency check
        rdy_val = 1'b1;
        push_frame(8'h00, 16'h1234, 16'h0000, 8'h26);
        @(posedge clk); #1 word_clk = 1'b1;
        @(posedge clk); @(negedge clk);
        check("latency_1clk_valid", {7'd0, txif.tx_valid}, 8'h00);
        @(posedge clk); @(negedge clk);
        check("latency_2clk_valid", {7'd0, txif.tx_valid}, 8'h01);
        #1 word_clk = 1'b0;
        wait_done("frame1");
        check("seq_after_frame1", seq_num, 8'h01);

        // frame 2: random ready, ch_data scrambled mid-frame
        rdy_rand = 1'b1;
        push_frame(8'h01, 16'h1234, 16'h0000, 8'h27);
        start_frame();
        repeat (4) @(posedge clk);
        #1 ch_data = {6{16'hDEAD}};
        wait_done("frame2_random_ready");
        check("seq_after_frame2", seq_num, 8'h02);
        rdy_rand = 1'b0;

        // three back-to-back all-FF frames from reset
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            push_frame(8'(f), 16'hFFFF, 16'hFFFF, 8'(f));
            start_frame();
            wait_done("ff_frame");
        end
        check("seq_after_ff", seq_num, 8'h03);

        // overrun while stalled
        rdy_val = 1'b0;
        push_frame(8'h03, 16'h1234, 16'h0000, 8'h25);
        start_frame();
        repeat (3) @(posedge clk);
        start_frame();
        @(negedge clk);
        check("overrun_set", {7'd0, overrun}, 8'h01);
        check("overrun_seq_unchanged", seq_num, 8'h03);
        @(posedge clk); #1 rdy_val = 1'b1;
        wait_done("overrun_frame");
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("no_extra_frame_busy", {7'd0, frame_busy}, 8'h00);
        check("overrun_seq_once", seq_num, 8'h04);
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        @(negedge clk);
        check("overrun_cleared", {7'd0, overrun}, 8'h00);

        // clear coinciding with a new overrun: set wins
        rdy_val = 1'b0;
        push_frame(8'h04, 16'h1234, 16'h0000, 8'h22);
        start_frame();
        repeat (2) @(posedge clk);
        #1 word_clk = 1'b1; ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        @(negedge clk);
        check("overrun_set_beats_clr", {7'd0, overrun}, 8'h01);
        #1 word_clk = 1'b0;
        rdy_val = 1'b1;
        wait_done("setwins_frame");
        check("seq_after_setwins", seq_num, 8'h05);
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;

        // reset mid-frame around byte 7
        push_frame(8'h05, 16'h1234, 16'h0000, 8'h23);
        start_frame();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(posedge clk); #2;
                if (exp_q.size() <= 8) hit = 1'b1;
            end
            tests++;
            if (!hit) begin
                fails++;
                $display("FAIL midframe_reach: got %0d bytes outstanding expected <=8", exp_q.size());
            end
        end
        rst = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("midframe_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        push_frame(8'h00, 16'h1234, 16'h0000, 8'h26);
        start_frame();
        wait_done("post_reset_frame");
        check("seq_post_reset", seq_num, 8'h01);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
